rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Sequential arbiter sharing the single combinational instruction ROM between two requesters: port 0 (instruction fetch) and port 1 (data load). Accepts byte-addressed, word-aligned read requests over valid/ready handshakes, drives the ROM word address, registers the returned word, and holds it as a response until the owning requester accepts it. Sits between the core's fetch/load units and the ROM instance.

## Interface

Parameters:
- MEM_WIDTH, 32: ROM word width, equal to the response data width.
- MEM_DEPTH, 64: ROM depth in words. ROM_ADDR_WIDTH = $clog2(MEM_DEPTH) is a localparam.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit 0 fetch, bit 1 load.
- req_addr0, req_addr1  in  32 each  per-port byte address.
- req_ready  out  2  per-port request accept.
- resp_valid  out  2  per-port response valid; at most one bit set.
- resp_ready  in  2  per-port response accept.
- resp_data  out  MEM_WIDTH  registered ROM word, shared by both ports.
- resp_err  out  1  response error flag, qualified by resp_valid.
- rom_addr  out  ROM_ADDR_WIDTH  word address to the ROM.
- rom_dout  in  MEM_WIDTH  combinational ROM read data.

## Operation

- Two-state FSM: IDLE, RESP.
- Accept ("fire") on port p when req_valid[p] && req_ready[p]; at most one port fires per cycle.
- req_ready is asserted only for the granted port, only in IDLE or in RESP when the pending response fires that same cycle.
- Grant: fixed priority, port 0 over port 1, unless the round-robin option is compiled in (see Configuration).
- On fire: rom_addr = req_addr[ROM_ADDR_WIDTH+1:2] of the firing port; rom_dout is captured into resp_data; owner register set to p; resp_err captured; FSM moves to RESP.
- When no port fires, rom_addr is held at its last value.
- Error: resp_err=1 when req_addr[1:0] != 0 or req_addr[31:2] >= MEM_DEPTH. On error, resp_data = 0 and rom_dout is ignored.
- RESP: resp_valid[owner] = 1, and resp_data/resp_err are held stable until resp_ready[owner].
- Response fire with no new request fire: FSM goes to IDLE. Response fire with a new request fire in the same cycle: FSM stays in RESP with the new owner and data (back-to-back).
- resp_ready on the non-owner port is ignored.

## Timing

- Reset values: FSM=IDLE, resp_valid=0, req_ready=0 during the reset cycle, resp_data=0, resp_err=0, rom_addr=0, owner=0, round-robin pointer=0.
- Latency: request fire in cycle N gives resp_valid in cycle N+1.
- Throughput: one word per cycle when the owner holds resp_ready high and requests are continuous.
- req_ready depends combinationally on resp_ready and req_valid. It has no dependency on rom_dout.
- Simultaneous requests: exactly one port is granted; the loser's req_valid must stay high and its address stable until its fire.
- Reset asserted mid-response: the response is dropped, no resp_valid in the following cycle, FSM=IDLE.

## Configuration

- ROM_ARB_ROUND_ROBIN_EN defined:
  - A 1-bit last-grant pointer, updated on each request fire.
  - On contention, the port not granted last wins.
  - Port 0 wins on contention after reset.
- ROM_ARB_ROUND_ROBIN_EN undefined: fixed priority, port 0 always wins. The pointer register is not instantiated.

## Structure

- Shared package rom_arb_pkg:
  - typedef enum logic {IDLE, RESP} rom_arb_state_t
  - localparam NUM_PORTS = 2
  - port index constants PORT_FETCH = 0, PORT_LOAD = 1
- One natural sub-module, rom_arb_grant: combinational grant selection from req_valid, pointer and can_accept. It outputs a one-hot grant and is the only place the macro is consulted.
- The ROM itself is instantiated outside this block.

## Test plan

- Reset then single fetch: port 0 requests addr 0x8 with ROM word[2]=0xDEADBEEF, resp_ready=1 → resp_valid[0] the next cycle, resp_data=0xDEADBEEF, resp_err=0, FSM back to IDLE.
- Backpressure: port 1 reads 0x4, resp_ready[1]=0 for 3 cycles → resp_valid[1] and resp_data stay stable for 4 cycles; req_ready stays 0 for a concurrent port 0 request; port 0 fires in the cycle resp_ready[1] rises.
- Contention: both ports request every cycle with resp_ready=11.
  - Fixed priority: port 0 always granted.
  - With ROM_ARB_ROUND_ROBIN_EN: grants alternate 0,1,0,1.
- Errors: addr 0x2 → resp_err=1, resp_data=0. Addr 4*MEM_DEPTH → resp_err=1, resp_data=0.
- Back-to-back streaming: port 0 sends 0x0, 0x4, 0x8, 0xC with resp_ready held high → four consecutive resp_valid cycles returning words 0–3 in order.
- Reset in RESP: rst asserted while resp_valid[1]=1 → next cycle resp_valid=0, FSM=IDLE; a subsequent request is served normally.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared types and constants for the ROM arbiter.
//   rom_arb_state_t : arbiter FSM state (IDLE, RESP)
//   NUM_PORTS       : number of requesters sharing the ROM
//   PORT_FETCH      : index of the instruction-fetch port
//   PORT_LOAD       : index of the data-load port
package rom_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } rom_arb_state_t;

    localparam int NUM_PORTS  = 2;
    localparam int PORT_FETCH = 0;
    localparam int PORT_LOAD  = 1;

endpackage

// File: rtl/rom_arb_grant.sv
// rom_arb_grant: picks which requester may fire this cycle.
// Build option: ROM_ARB_ROUND_ROBIN_EN selects round-robin on contention;
// without it port 0 (fetch) always wins.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (used only by the
//                 round-robin priority flop)
//   req_valid   : per-port request valid
//   can_accept  : the arbiter can take a new request this cycle
//   grant       : one-hot grant, zero when nothing may fire
module rom_arb_grant
    import rom_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic                 can_accept,
    output logic [NUM_PORTS-1:0] grant
);

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // prio holds the port that wins the next contention, i.e. the port that
    // was not granted last. Resetting it to 0 lets fetch win first.
    logic prio;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (grant != '0) begin
            prio <= grant[PORT_FETCH];
        end
    end

    always_comb begin
        grant = '0;
        if (can_accept) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end
`else
    logic unused_rr;
    assign unused_rr = &{1'b0, clk, rst};

    always_comb begin
        grant = '0;
        if (can_accept) begin
            if (req_valid[PORT_FETCH]) begin
                grant[PORT_FETCH] = 1'b1;
            end else if (req_valid[PORT_LOAD]) begin
                grant[PORT_LOAD] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational instruction ROM between the fetch
// port (0) and the load port (1). A request is accepted, the ROM is read in
// the same cycle, and the registered word is held as a response until the
// owning port takes it.
// Build option: ROM_ARB_ROUND_ROBIN_EN (see rom_arb_grant).
// Handshake: a transfer happens on a port in a cycle where both valid and
// ready are high; a valid source keeps its payload stable until then.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-port request handshake
//   req_addr0/req_addr1  : byte address of port 0 / port 1
//   resp_valid/resp_ready: per-port response handshake (one valid at a time)
//   resp_data, resp_err  : registered ROM word and error flag
//   rom_addr, rom_dout   : word address to / read data from the ROM
//   dbg_state            : current FSM state (0 IDLE, 1 RESP)
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         req_valid,
    input  logic [31:0]                        req_addr0,
    input  logic [31:0]                        req_addr1,
    output logic [1:0]                         req_ready,
    output logic [1:0]                         resp_valid,
    input  logic [1:0]                         resp_ready,
    output logic [MEM_WIDTH-1:0]               resp_data,
    output logic                               resp_err,
    output logic [$clog2(MEM_DEPTH)-1:0]       rom_addr,
    input  logic [MEM_WIDTH-1:0]               rom_dout,
    output logic                               dbg_state
);

    localparam int ROM_ADDR_WIDTH = $clog2(MEM_DEPTH);

    rom_arb_state_t              state_q, state_d;
    logic                        owner_q;
    logic [MEM_WIDTH-1:0]        data_q;
    logic                        err_q;
    logic [ROM_ADDR_WIDTH-1:0]   rom_addr_q;

    logic                        resp_fire;
    logic                        can_accept;
    logic [NUM_PORTS-1:0]        grant;
    logic                        req_fire;
    logic                        fire_port;
    logic [31:0]                 sel_addr;
    logic                        sel_err;

    // A new request can slot in while the pending response leaves, which
    // is what allows one word per cycle.
    assign resp_fire  = (state_q == RESP) && resp_ready[owner_q];
    assign can_accept = !rst && ((state_q == IDLE) || resp_fire);

    rom_arb_grant u_grant (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .can_accept (can_accept),
        .grant      (grant)
    );

    assign req_ready = grant;
    assign req_fire  = grant != '0;
    assign fire_port = grant[PORT_LOAD];
    assign sel_addr  = fire_port ? req_addr1 : req_addr0;
    assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(MEM_DEPTH));

    // The ROM is combinational, so the firing address goes straight out;
    // otherwise the last address is held.
    always_comb begin
        rom_addr = rom_addr_q;
        if (rst) begin
            rom_addr = '0;
        end else if (req_fire) begin
            rom_addr = sel_addr[ROM_ADDR_WIDTH+1:2];
        end
    end

    always_comb begin
        state_d = state_q;
        if (req_fire) begin
            state_d = RESP;
        end else if (resp_fire) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr;
            if (req_fire) begin
                owner_q <= fire_port;
                err_q   <= sel_err;
                data_q  <= sel_err ? '0 : rom_dout;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    assign resp_data = data_q;
    assign resp_err  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: self-checking bench for rom_arbiter with a behavioural ROM.
module tb_rom_arbiter;

    localparam int MEM_WIDTH = 32;
    localparam int MEM_DEPTH = 64;
    localparam int AW        = $clog2(MEM_DEPTH);
    localparam int W         = 35;  // {port one-hot, err, data}

    logic                 clk;
    logic                 rst;
    logic [1:0]           req_valid;
    logic [31:0]          req_addr0;
    logic [31:0]          req_addr1;
    logic [1:0]           req_ready;
    logic [1:0]           resp_valid;
    logic [1:0]           resp_ready;
    logic [MEM_WIDTH-1:0] resp_data;
    logic                 resp_err;
    logic [AW-1:0]        rom_addr;
    logic [MEM_WIDTH-1:0] rom_dout;
    logic                 dbg_state;

    logic [MEM_WIDTH-1:0] rom [MEM_DEPTH];
    logic [W-1:0]         exp_q[$];
    logic [W-1:0]         mon_e;
    int                   n_checks;
    int                   n_errors;

    rom_arbiter #(.MEM_WIDTH(MEM_WIDTH), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .dbg_state  (dbg_state)
    );

    assign rom_dout = rom[rom_addr];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_word(input int p, input logic [31:0] a);
        logic        err;
        logic [31:0] data;
        logic [1:0]  onehot;
        err    = (a[1:0] != 2'b00) || (a[31:2] >= 30'(MEM_DEPTH));
        data   = err ? 32'h0 : rom[a[AW+1:2]];
        onehot = (p == 1) ? 2'b10 : 2'b01;
        return {onehot, err, data};
    endfunction

    // scoreboard: pop and compare on every response handshake
    always @(negedge clk) begin
        if (!rst && ((resp_valid & resp_ready) != 2'b00)) begin
            if (exp_q.size() == 0) begin
                check_eq("resp_unexpected", 64'(resp_valid), 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("resp_port", 64'(resp_valid), 64'(mon_e[34:33]));
                check_eq("resp_err",  64'(resp_err),   64'(mon_e[32]));
                check_eq("resp_data", 64'(resp_data),  64'(mon_e[31:0]));
            end
        end
    end

    // driver tasks; all return one time unit after a rising edge
    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        req_valid = 2'b00;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic send(input int p, input logic [31:0] a);
        int n;
        if (p == 1) req_addr1 = a; else req_addr0 = a;
        req_valid[p] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[p] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[p]) begin
            check_eq("req_timeout", 64'h0, 64'h1);
        end else begin
            exp_q.push_back(exp_word(p, a));
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_addr0  = 32'h0;
        req_addr1  = 32'h0;
        resp_ready = 2'b00;
        for (int i = 0; i < MEM_DEPTH; i++) rom[i] = $urandom();
        rom[2] = 32'hDEADBEEF;

        // reset state, with requests pending to confirm nothing is accepted
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        req_addr0 = 32'h10;
        req_addr1 = 32'h14;
        @(negedge clk);
        check_eq("rst_req_ready",  64'(req_ready),  64'h0);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'h0);
        check_eq("rst_resp_data",  64'(resp_data),  64'h0);
        check_eq("rst_resp_err",   64'(resp_err),   64'h0);
        check_eq("rst_rom_addr",   64'(rom_addr),   64'h0);
        check_eq("rst_state",      64'(dbg_state),  64'h0);
        do_reset(1);

        // single fetch
        resp_ready = 2'b11;
        send(0, 32'h8);
        @(negedge clk);
        check_eq("fetch_resp_valid", 64'(resp_valid), 64'h1);
        check_eq("fetch_state",      64'(dbg_state),  64'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("fetch_idle_valid", 64'(resp_valid), 64'h0);
        check_eq("fetch_idle_state", 64'(dbg_state),  64'h0);
        @(posedge clk);
        #1;

        // backpressure on port 1 with a concurrent port 0 request
        resp_ready = 2'b00;
        send(1, 32'h4);
        req_addr0    = 32'hC;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_resp_valid", 64'(resp_valid), 64'h2);
            check_eq("bp_resp_data",  64'(resp_data),  64'(rom[1]));
            check_eq("bp_req_ready",  64'(req_ready),  64'h0);
            @(posedge clk);
            #1;
        end
        resp_ready = 2'b11;
        @(negedge clk);
        check_eq("bp_release_ready", 64'(req_ready), 64'h1);
        check_eq("bp_release_data",  64'(resp_data), 64'(rom[1]));
        exp_q.push_back(exp_word(0, 32'hC));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        drain();

        // errors: misaligned and past the end
        send(0, 32'h2);
        send(1, 32'(4 * MEM_DEPTH));
        send(0, 32'h1_0000_0 + 32'h4);
        drain();

        // back-to-back stream on port 0
        req_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr0 = 32'(i * 4);
            @(negedge clk);
            check_eq("stream_req_ready", 64'(req_ready), 64'h1);
            if (i > 0) check_eq("stream_resp_valid", 64'(resp_valid), 64'h1);
            exp_q.push_back(exp_word(0, 32'(i * 4)));
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("stream_last_valid", 64'(resp_valid), 64'h1);
        @(posedge clk);
        #1;
        drain();

        // contention from a fresh reset so the arbitration history is known
        do_reset(2);
        resp_ready = 2'b11;
        req_addr0  = 32'h10;
        req_addr1  = 32'h14;
        req_valid  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
`ifdef ROM_ARB_ROUND_ROBIN_EN
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            g = 2'b01;
`endif
            @(negedge clk);
            check_eq("cont_grant", 64'(req_ready), 64'(g));
            exp_q.push_back(exp_word(g[1] ? 1 : 0, g[1] ? req_addr1 : req_addr0));
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        drain();

        // reset while a response is pending
        resp_ready = 2'b00;
        send(1, 32'h8);
        @(negedge clk);
        check_eq("rr_pending_valid", 64'(resp_valid), 64'h2);
        @(posedge clk);
        #1;
        do_reset(1);
        @(negedge clk);
        check_eq("rr_after_valid", 64'(resp_valid), 64'h0);
        check_eq("rr_after_state", 64'(dbg_state),  64'h0);
        @(posedge clk);
        #1;
        resp_ready = 2'b11;
        send(0, 32'h8);
        drain();

        // random single requests
        for (int i = 0; i < 20; i++) begin
            int          p;
            logic [31:0] a;
            p = $urandom_range(0, 1);
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 511))
                                            : 32'($urandom_range(0, MEM_DEPTH - 1) * 4);
            send(p, a);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
